// File: rtl/wb_console_pkg.sv
// Shared constants for the Wishbone console: register map, STATUS layout and
// the byte-stream signatures that raise the sticky done/err flags.
package wb_console_pkg;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_off_e;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_DONE    = 2;
  localparam int ST_ERR     = 3;
  localparam int ST_OVF     = 4;
  localparam int ST_LVL_LSB = 8;
  localparam int ST_LVL_W   = 9;

  localparam logic [31:0] SIG_DONE = 32'h444F_4E45;
  localparam logic [23:0] SIG_ERR  = 24'h45_5252;

  function automatic logic [31:0] pack_status(
    input logic                full,
    input logic                empty,
    input logic                done,
    input logic                err,
    input logic                ovf,
    input logic [ST_LVL_W-1:0] level
  );
    logic [31:0] s;
    s                            = '0;
    s[ST_FULL]                   = full;
    s[ST_EMPTY]                  = empty;
    s[ST_DONE]                   = done;
    s[ST_ERR]                    = err;
    s[ST_OVF]                    = ovf;
    s[ST_LVL_LSB +: ST_LVL_W]    = level;
    return s;
  endfunction

endpackage

// File: rtl/wb_console_fifo.sv
// Byte FIFO for the console TX path; head byte is read straight from storage.
module wb_console_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_in,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop_ok ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/wb_console.sv
// Wishbone-attached debug console: TX byte FIFO plus sticky DONE/ERR
// signature detection over the pushed byte stream.
module wb_console
  import wb_console_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_be_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        done_o,
  output logic        err_o
);

  localparam int LW = $clog2(DEPTH) + 1;

  reg_off_e      off;
  logic          acc, push, clr;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] level;
  logic [31:0]   rd_d;
  logic          ack_q;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   sig_q, sig_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic          unused_ok;

  assign unused_ok = ^{wb_dat_i[31:8], wb_be_i[3:1]};

  assign off  = reg_off_e'(wb_adr_i);
  assign acc  = wb_cyc_i & wb_stb_i & ~ack_q;
  assign push = acc & wb_we_i & (off == REG_TXDATA) & wb_be_i[0];
  assign clr  = acc & wb_we_i & (off == REG_CTRL) & wb_dat_i[0];

  wb_console_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_in  (rst_in),
    .push_i  (push),
    .data_i  (wb_dat_i[7:0]),
    .pop_i   (tx_ready_i),
    .data_o  (tx_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  always_comb begin
    rd_d = '0;
    if (off == REG_STATUS)
      rd_d = pack_status(fifo_full, fifo_empty, done_q, err_q, ovf_q, ST_LVL_W'(level));
  end

  // Flags look at the registered signature, so they rise one cycle after it matches.
  always_comb begin
    dat_d  = (acc & ~wb_we_i) ? rd_d : dat_q;
    sig_d  = (push & ~fifo_full) ? {sig_q[23:0], wb_dat_i[7:0]} : sig_q;
    done_d = done_q | (sig_q == SIG_DONE);
    err_d  = err_q | (sig_q[23:0] == SIG_ERR);
    ovf_d  = ovf_q | (push & fifo_full);
    if (clr) begin
      sig_d  = '0;
      done_d = 1'b0;
      err_d  = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      sig_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ack_q  <= acc;
      dat_q  <= dat_d;
      sig_q  <= sig_d;
      done_q <= done_d;
      err_q  <= err_d;
      ovf_q  <= ovf_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign tx_valid_o = ~fifo_empty;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_wb_console.sv
// Randomized scoreboard bench for wb_console against a transaction-level model.
module tb_wb_console;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  be;
  logic [1:0]  adr;
  logic [31:0] wdat, rdat;
  logic        ack;
  logic [7:0]  txd;
  logic        txv, txr;
  logic        done, err;

  always #5 clk = ~clk;

  wb_console #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_in     (rst_n),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_be_i    (be),
    .wb_adr_i   (adr),
    .wb_dat_i   (wdat),
    .wb_dat_o   (rdat),
    .wb_ack_o   (ack),
    .tx_data_o  (txd),
    .tx_valid_o (txv),
    .tx_ready_i (txr),
    .done_o     (done),
    .err_o      (err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: FIFO occupancy, sticky flags, recent accepted bytes.
  bit          ack_m = 0;
  int          cnt_m = 0;
  bit          done_m = 0, err_m = 0, ovf_m = 0;
  logic [31:0] last_rd = '0;
  logic [7:0]  recent[$];
  logic [31:0] exp_rd[$];
  logic [7:0]  exp_tx[$];

  function automatic bit tail_done();
    int n = recent.size();
    return n >= 4 && recent[n-4] == "D" && recent[n-3] == "O" &&
           recent[n-2] == "N" && recent[n-1] == "E";
  endfunction

  function automatic bit tail_err();
    int n = recent.size();
    return n >= 3 && recent[n-3] == "E" && recent[n-2] == "R" && recent[n-1] == "R";
  endfunction

  function automatic logic [31:0] read_model(input logic [1:0] a);
    if (a == 2'd1)
      return {15'd0, 9'(cnt_m), 3'd0, ovf_m, err_m, done_m, cnt_m == 0, cnt_m == DEPTH};
    return 32'd0;
  endfunction

  always @(negedge clk) begin
    bit acc, pop, full_pre, done_n, err_n;
    chk("ack", {31'd0, ack}, {31'd0, ack_m});
    chk("tx_valid", {31'd0, txv}, {31'd0, cnt_m != 0});
    chk("done_o", {31'd0, done}, {31'd0, done_m});
    chk("err_o", {31'd0, err}, {31'd0, err_m});
    if (rst_n !== 1'b1) begin
      ack_m = 0; cnt_m = 0; done_m = 0; err_m = 0; ovf_m = 0; last_rd = '0;
      recent.delete(); exp_rd.delete(); exp_tx.delete();
    end else begin
      acc      = cyc && stb && !ack_m;
      pop      = (cnt_m != 0) && txr;
      full_pre = (cnt_m == DEPTH);
      done_n   = done_m || tail_done();
      err_n    = err_m || tail_err();
      if (acc) begin
        if (!we) last_rd = read_model(adr);
        exp_rd.push_back(last_rd);
        if (we && adr == 2'd0 && be[0]) begin
          if (full_pre) ovf_m = 1;
          else begin
            cnt_m++;
            exp_tx.push_back(wdat[7:0]);
            recent.push_back(wdat[7:0]);
            if (recent.size() > 4) void'(recent.pop_front());
          end
        end
        if (we && adr == 2'd2 && wdat[0]) begin
          done_n = 0; err_n = 0; ovf_m = 0; recent.delete();
        end
      end
      if (pop) cnt_m--;
      done_m = done_n;
      err_m  = err_n;
      ack_m  = acc;
    end
  end

  // Monitor: consume expectations whenever the DUT presents a response or a byte.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ack === 1'b1) begin
        if (exp_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected: got ack with data %h, required no ack", rdat);
        end else chk("wb_dat_o", rdat, exp_rd.pop_front());
      end
      if (txv === 1'b1 && txr === 1'b1) begin
        if (exp_tx.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected: got byte %h, required none", txd);
        end else chk("tx_data", {24'd0, txd}, {24'd0, exp_tx.pop_front()});
      end
    end
  end

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    int n = 0;
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; be = b;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 10);
    if (ack !== 1'b1) begin
      checks++; failures++;
      $display("FAIL bus_timeout: got no ack, required ack within 10 cycles");
    end
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] chars [6];
    logic [5:0] pat;
    chars = '{8'h44, 8'h4F, 8'h4E, 8'h45, 8'h52, 8'h78};
    rst_n = 0; cyc = 0; stb = 0; we = 0; be = 0; adr = 0; wdat = 0; txr = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Single byte through with sink ready.
    txr = 1;
    bus(1, 2'd0, 32'h41, 4'hF);
    idle(3);
    bus(0, 2'd1, 0, 4'hF);

    // Fill past capacity with sink stalled, then drain in order.
    txr = 0;
    for (int i = 0; i < DEPTH + 1; i++) bus(1, 2'd0, 32'h10 + i, 4'h1);
    bus(0, 2'd1, 0, 4'hF);
    txr = 1;
    idle(DEPTH + 3);
    bus(0, 2'd1, 0, 4'hF);
    bus(1, 2'd2, 32'h1, 4'hF);

    // DONE signature, then clear.
    bus(1, 2'd0, "D", 4'h1); bus(1, 2'd0, "O", 4'h1);
    bus(1, 2'd0, "N", 4'h1); bus(1, 2'd0, "E", 4'h1);
    @(negedge clk);
    chk("done_after_sig", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    bus(1, 2'd2, 32'h1, 4'hF);
    @(negedge clk);
    chk("done_cleared", {31'd0, done}, 32'd0);
    @(posedge clk); #1;

    // ERR signature.
    bus(1, 2'd0, "x", 4'h1); bus(1, 2'd0, "E", 4'h1);
    bus(1, 2'd0, "R", 4'h1); bus(1, 2'd0, "R", 4'h1);
    @(negedge clk);
    chk("err_after_sig", {31'd0, err}, 32'd1);
    chk("done_not_set", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    bus(0, 2'd1, 0, 4'hF);
    bus(1, 2'd2, 32'h1, 4'hF);

    // Strobe held six cycles on the reserved offset.
    cyc = 1; stb = 1; we = 0; adr = 2'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = ack;
    end
    @(posedge clk); #1;
    cyc = 0; stb = 0;
    chk("held_stb_ack_pattern", {26'd0, pat}, {26'd0, 6'b101010});

    // Reset landing on the acceptance edge of a write.
    idle(2);
    cyc = 1; stb = 1; we = 1; adr = 2'd0; wdat = 32'h5A; be = 4'hF; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1; cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    chk("no_ack_after_rst", {31'd0, ack}, 32'd0);
    chk("empty_after_rst", {31'd0, txv}, 32'd0);
    @(posedge clk); #1;
    bus(0, 2'd1, 0, 4'hF);

    // Randomized mix of accesses and sink back-pressure.
    for (int k = 0; k < 300; k++) begin
      int op;
      txr = 1'($urandom_range(0, 1));
      op  = $urandom_range(0, 9);
      if (op <= 4)
        bus(1, 2'd0, {$urandom(), chars[$urandom_range(0, 5)]} & 32'hFFFF_FFFF,
            ($urandom_range(0, 4) == 0) ? 4'he : 4'hf);
      else if (op <= 6) bus(0, 2'd1, $urandom(), 4'hF);
      else if (op == 7) bus(1, 2'd2, ($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0, 4'hF);
      else if (op == 8) bus(1'($urandom_range(0, 1)), 2'd3, $urandom(), 4'hF);
      else bus(0, 2'($urandom_range(0, 3)), 0, 4'hF);
    end

    txr = 1;
    idle(DEPTH + 6);
    chk("tx_all_drained", exp_tx.size(), 32'd0);
    chk("rd_all_acked", exp_rd.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
